// File: rtl/sfifo_wr_arbiter_if.sv
// Shared-write-port bundle between NumReq producers, the round-robin arbiter and one SFIFO.
// master: the arbiter side; slave: the producers plus the FIFO side.
interface sfifo_wr_arbiter_if #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 8,
  parameter int unsigned IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
);

  logic [NumReq-1:0]       ReqVec;
  logic [NumReq*Width-1:0] ReqData;
  logic                    FIFOFull;
  logic                    FIFOWrReq;
  logic [Width-1:0]        WRData;
  logic [NumReq-1:0]       AckVec;
  logic [IdW-1:0]          GrantId;
  logic                    Busy;

  modport master (
    input  ReqVec,
    input  ReqData,
    input  FIFOFull,
    output FIFOWrReq,
    output WRData,
    output AckVec,
    output GrantId,
    output Busy
  );

  modport slave (
    output ReqVec,
    output ReqData,
    output FIFOFull,
    input  FIFOWrReq,
    input  WRData,
    input  AckVec,
    input  GrantId,
    input  Busy
  );

endinterface

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one SFIFO write port among NumReq producers.
// An owner keeps the grant for up to BurstLen accepted beats, or while stalled on FIFOFull.
module sfifo_wr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Width    = 8,
  parameter int unsigned BurstLen = 4
) (
  input logic                clk,
  input logic                reset,
  sfifo_wr_arbiter_if.master bus
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(BurstLen + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLock = 1'b1;

  // (id + k) mod NumReq for id, k < NumReq; correct for non-power-of-2 NumReq.
  function automatic logic [IdW-1:0] inc_wrap(input logic [IdW-1:0] id, input int unsigned k);
    int unsigned sum;
    sum = 32'(id) + k;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end
    return IdW'(sum);
  endfunction

  logic [0:0]        r_state;
  logic [IdW-1:0]    r_ptr;
  logic [IdW-1:0]    r_owner;
  logic [CntW-1:0]   r_cnt;

  logic [0:0]        w_state_nxt;
  logic [IdW-1:0]    w_ptr_nxt;
  logic [IdW-1:0]    w_owner_nxt;
  logic [CntW-1:0]   w_cnt_nxt;

  logic [IdW-1:0]    w_scan_id;
  logic              w_scan_hit;
  logic              w_lock;
  logic [IdW-1:0]    w_cur;
  logic              w_valid;
  logic              w_write;
  logic [CntW-1:0]   w_cnt_inc;
  logic [Width-1:0]  w_wr_data;
  logic [NumReq-1:0] w_ack;

  // First requester at or after r_ptr, wrapping past NumReq-1.
  always_comb begin
    w_scan_id  = r_ptr;
    w_scan_hit = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_scan_hit && bus.ReqVec[inc_wrap(r_ptr, k)]) begin
        w_scan_id  = inc_wrap(r_ptr, k);
        w_scan_hit = 1'b1;
      end
    end
  end

  assign w_lock    = (r_state == StLock);
  assign w_cur     = w_lock ? r_owner : w_scan_id;
  assign w_valid   = w_lock ? bus.ReqVec[r_owner] : w_scan_hit;
  assign w_write   = w_valid & ~bus.FIFOFull & reset;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_wr_data = '0;
    w_ack     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_cur == IdW'(i)) begin
        w_wr_data = bus.ReqData[i*Width +: Width];
        w_ack[i]  = w_write;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_write) begin
          if (BurstLen == 1) begin
            w_ptr_nxt = inc_wrap(w_cur, 1);
          end else begin
            w_owner_nxt = w_cur;
            w_cnt_nxt   = CntW'(1);
            w_state_nxt = StLock;
          end
        end else if (w_valid) begin
          // Stalled on full: lock so no other producer can overtake this one.
          w_owner_nxt = w_cur;
          w_cnt_nxt   = '0;
          w_state_nxt = StLock;
        end
      end
      StLock: begin
        if (w_write) begin
          if (w_cnt_inc == CntW'(BurstLen)) begin
            w_ptr_nxt   = inc_wrap(r_owner, 1);
            w_cnt_nxt   = '0;
            w_state_nxt = StIdle;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (!bus.ReqVec[r_owner]) begin
          w_ptr_nxt   = inc_wrap(r_owner, 1);
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.FIFOWrReq = w_write;
  assign bus.WRData    = w_wr_data;
  assign bus.AckVec    = w_ack;
  assign bus.GrantId   = w_cur;
  assign bus.Busy      = w_lock;

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Directed bench for sfifo_wr_arbiter: 4-producer burst arbiter, 3-producer wrap/reset,
// and a 3-producer BurstLen=1 instance.
module tb_sfifo_wr_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;

  int n_total;
  int n_pass;
  int n_fail;

  sfifo_wr_arbiter_if #(.NumReq(4), .Width(8)) bus_a ();
  sfifo_wr_arbiter_if #(.NumReq(3), .Width(8)) bus_b ();
  sfifo_wr_arbiter_if #(.NumReq(3), .Width(8)) bus_c ();

  sfifo_wr_arbiter #(.NumReq(4), .Width(8), .BurstLen(4)) u_dut_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (bus_a)
  );

  sfifo_wr_arbiter #(.NumReq(3), .Width(8), .BurstLen(4)) u_dut_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (bus_b)
  );

  sfifo_wr_arbiter #(.NumReq(3), .Width(8), .BurstLen(1)) u_dut_c (
    .clk  (clk),
    .reset(rst_c),
    .bus  (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    bus_a.ReqVec = '0;
    bus_a.FIFOFull = 1'b0;
    nxt();
    nxt();
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    bus_b.ReqVec = '0;
    bus_b.FIFOFull = 1'b0;
    nxt();
    nxt();
    rst_b = 1'b1;
  endtask

  logic [7:0] data_a [4];
  logic [7:0] data_b [3];

  initial begin
    int g;
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    data_a  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    data_b  = '{8'h3C, 8'h4B, 8'h5A};
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    bus_a.ReqData = 32'hD3C2_B1A0;
    bus_b.ReqData = 24'h5A4B3C;
    bus_c.ReqData = 24'h5A4B3C;
    bus_a.FIFOFull = 1'b0;
    bus_b.FIFOFull = 1'b0;
    bus_c.FIFOFull = 1'b0;
    bus_b.ReqVec = '0;
    bus_c.ReqVec = '0;

    // Reset holds off writes even with every producer requesting
    bus_a.ReqVec = 4'hF;
    nxt();
    nxt();
    settle();
    chk("t1 rst wrreq", 32'(bus_a.FIFOWrReq), 32'd0);
    chk("t1 rst ack", 32'(bus_a.AckVec), 32'd0);
    chk("t1 rst busy", 32'(bus_a.Busy), 32'd0);
    nxt();
    rst_a = 1'b1;

    // All four requesting: bursts of four, 0,1,2,3 then back to 0
    for (int c = 0; c < 17; c++) begin
      g = (c / 4) % 4;
      settle();
      chk($sformatf("t3 grant c%0d", c), 32'(bus_a.GrantId), 32'(g));
      chk($sformatf("t3 ack c%0d", c), 32'(bus_a.AckVec), 32'(1 << g));
      chk($sformatf("t3 data c%0d", c), 32'(bus_a.WRData), 32'(data_a[g]));
      nxt();
    end

    // Lone requester 2: re-granted after rotate with no bubble
    reset_a();
    bus_a.ReqVec = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk($sformatf("t2 wrreq c%0d", c), 32'(bus_a.FIFOWrReq), 32'd1);
      chk($sformatf("t2 ack c%0d", c), 32'(bus_a.AckVec), 32'h4);
      chk($sformatf("t2 busy c%0d", c), 32'(bus_a.Busy), (c == 1 || c == 5) ? 32'd0 : 32'd1);
      nxt();
    end

    // Owner 1 stalls on full after two beats, then finishes its burst
    reset_a();
    bus_a.ReqVec = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("t4 beat%0d grant", c + 1), 32'(bus_a.GrantId), 32'd1);
      chk($sformatf("t4 beat%0d ack", c + 1), 32'(bus_a.AckVec), 32'h2);
      nxt();
    end
    bus_a.FIFOFull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t4 full%0d wrreq", c), 32'(bus_a.FIFOWrReq), 32'd0);
      chk($sformatf("t4 full%0d ack", c), 32'(bus_a.AckVec), 32'd0);
      chk($sformatf("t4 full%0d grant", c), 32'(bus_a.GrantId), 32'd1);
      chk($sformatf("t4 full%0d busy", c), 32'(bus_a.Busy), 32'd1);
      nxt();
    end
    bus_a.FIFOFull = 1'b0;
    for (int c = 2; c < 4; c++) begin
      settle();
      chk($sformatf("t4 beat%0d grant", c + 1), 32'(bus_a.GrantId), 32'd1);
      chk($sformatf("t4 beat%0d ack", c + 1), 32'(bus_a.AckVec), 32'h2);
      nxt();
    end
    settle();
    chk("t4 next grant", 32'(bus_a.GrantId), 32'd2);
    chk("t4 next ack", 32'(bus_a.AckVec), 32'h4);
    nxt();

    // Owner 0 drops after one beat: one dead cycle, then producer 1
    reset_a();
    bus_a.ReqVec = 4'hF;
    settle();
    chk("t5 first ack", 32'(bus_a.AckVec), 32'h1);
    nxt();
    bus_a.ReqVec = 4'hE;
    settle();
    chk("t5 drop wrreq", 32'(bus_a.FIFOWrReq), 32'd0);
    chk("t5 drop busy", 32'(bus_a.Busy), 32'd1);
    nxt();
    settle();
    chk("t5 regrant id", 32'(bus_a.GrantId), 32'd1);
    chk("t5 regrant ack", 32'(bus_a.AckVec), 32'h2);
    chk("t5 regrant busy", 32'(bus_a.Busy), 32'd0);
    nxt();

    // Full while idle: producer 3 locks and producer 0 cannot overtake
    reset_a();
    bus_a.FIFOFull = 1'b1;
    bus_a.ReqVec = 4'b1000;
    settle();
    chk("t7 idle full wrreq", 32'(bus_a.FIFOWrReq), 32'd0);
    chk("t7 idle full grant", 32'(bus_a.GrantId), 32'd3);
    nxt();
    bus_a.ReqVec = 4'b1001;
    settle();
    chk("t7 stall busy", 32'(bus_a.Busy), 32'd1);
    chk("t7 stall grant", 32'(bus_a.GrantId), 32'd3);
    chk("t7 stall wrreq", 32'(bus_a.FIFOWrReq), 32'd0);
    nxt();
    bus_a.FIFOFull = 1'b0;
    settle();
    chk("t7 unstall ack", 32'(bus_a.AckVec), 32'h8);
    nxt();
    bus_a.ReqVec = 4'b0001;
    settle();
    chk("t7 drop ack", 32'(bus_a.AckVec), 32'd0);
    nxt();
    settle();
    chk("t7 wrap grant", 32'(bus_a.GrantId), 32'd0);
    chk("t7 wrap ack", 32'(bus_a.AckVec), 32'h1);
    chk("t7 wrap busy", 32'(bus_a.Busy), 32'd0);
    nxt();

    // No requests: stays idle, no write
    reset_a();
    nxt();
    settle();
    chk("t8 none wrreq", 32'(bus_a.FIFOWrReq), 32'd0);
    chk("t8 none busy", 32'(bus_a.Busy), 32'd0);
    nxt();

    // NumReq=3: reset mid-burst of producer 2
    reset_b();
    bus_b.ReqVec = 3'b100;
    settle();
    chk("t6 b grant", 32'(bus_b.GrantId), 32'd2);
    chk("t6 b ack", 32'(bus_b.AckVec), 32'h4);
    nxt();
    settle();
    chk("t6 b busy", 32'(bus_b.Busy), 32'd1);
    nxt();
    rst_b = 1'b0;
    bus_b.ReqVec = 3'b111;
    settle();
    chk("t6 rst wrreq", 32'(bus_b.FIFOWrReq), 32'd0);
    chk("t6 rst ack", 32'(bus_b.AckVec), 32'd0);
    nxt();
    rst_b = 1'b1;
    settle();
    chk("t6 post grant", 32'(bus_b.GrantId), 32'd0);
    chk("t6 post ack", 32'(bus_b.AckVec), 32'h1);
    chk("t6 post busy", 32'(bus_b.Busy), 32'd0);
    nxt();

    // NumReq=3, ReqVec=101: 0x4, 2x4, then wrap to 0
    reset_b();
    bus_b.ReqVec = 3'b101;
    for (int c = 0; c < 9; c++) begin
      g = (c >= 4 && c < 8) ? 2 : 0;
      settle();
      chk($sformatf("t6 wrap grant c%0d", c), 32'(bus_b.GrantId), 32'(g));
      chk($sformatf("t6 wrap data c%0d", c), 32'(bus_b.WRData), 32'(data_b[g]));
      nxt();
    end

    // BurstLen=1: rotate every beat, never busy
    rst_c = 1'b1;
    bus_c.ReqVec = 3'b111;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("bl1 grant c%0d", c), 32'(bus_c.GrantId), 32'(c % 3));
      chk($sformatf("bl1 ack c%0d", c), 32'(bus_c.AckVec), 32'(1 << (c % 3)));
      chk($sformatf("bl1 busy c%0d", c), 32'(bus_c.Busy), 32'd0);
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
